// File: rtl/sram_like_mem_responder.sv
// rtl/sram_like_mem_responder.sv - SRAM-like request/response slave driving a synchronous SRAM port
module sram_like_mem_responder #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, CAPTURE} state_t;

    // WAIT is entered at the handshake edge and leaves when the counter reads
    // zero, so loading LATENCY-1 yields exactly LATENCY wait cycles.
    localparam logic [2:0] WAIT_LOAD = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    state_t     state;
    logic [2:0] cnt;
    logic       lat_wr;
    logic [3:0] lat_wen;
    logic [3:0] mask;

    // Address bits above the SRAM word range are not decoded.
    logic [31-ADDR_W-2:0] unused_addr_hi;
    assign unused_addr_hi = addr[31:ADDR_W+2];

    // Only IDLE accepts a request; held low while reset is asserted.
    assign addr_ok = (state == IDLE) && resetn;

    // Byte-lane mask from size and the low address bits.
    always_comb begin
        mask = 4'b1111;
        case (size)
            2'd0:    mask = 4'b0001 << addr[1:0];
            2'd1:    mask = addr[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    // Transaction FSM with registered SRAM strobes and response outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            lat_wr    <= 1'b0;
            lat_wen   <= 4'b0000;
            data_ok   <= 1'b0;
            rdata     <= 32'd0;
            mem_en    <= 1'b0;
            mem_wen   <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            data_ok <= 1'b0;
            mem_en  <= 1'b0;
            mem_wen <= 4'b0000;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_wr    <= wr;
                        lat_wen   <= wr ? mask : 4'b0000;
                        mem_addr  <= addr[ADDR_W+1:2];
                        mem_wdata <= wdata;
                        if (LATENCY > 0) begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end else begin
                            state   <= ACCESS;
                            mem_en  <= 1'b1;
                            mem_wen <= wr ? mask : 4'b0000;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 3'd0) begin
                        state   <= ACCESS;
                        mem_en  <= 1'b1;
                        mem_wen <= lat_wen;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ACCESS: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (!lat_wr) begin
                        rdata <= mem_rdata;
                    end
                    data_ok <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
